mem_responder: RTL and testbench

- Memory-side responder for the 32-bit byte-addressed read/write memory bus. Lab benches and the datapath drive this bus as initiators.
- Holds a word array and accepts one request per transaction, with a ready/valid handshake.
- Returns read data, write acknowledgements and an error flag for misaligned, out-of-range or conflicting requests.

---
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-array memory responder with ready/valid request handshake
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   address    byte address of the request
//   memIn      write data
//   read       read request
//   write      write request
//   ready      high in IDLE: a request is accepted at the next rising edge
//   memOut     read data, valid while rd_valid=1
//   rd_valid   one-cycle pulse, read data present
//   wr_ack     one-cycle pulse, write committed
//   err        one-cycle pulse, request rejected (conflict, misaligned, out of range)
//   req_count  accepted requests including rejected ones, wraps at 16 bits
//
// Optional feature macro: MEM_CLEAR_ON_RESET_EN
//   defined:   every word is forced to FILL_WORD while rst_n=0
//   undefined: array is plain RAM and keeps its contents across reset

module mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] FILL_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] memIn,
    input  logic        read,
    input  logic        write,
    output logic        ready,
    output logic [31:0] memOut,
    output logic        rd_valid,
    output logic        wr_ack,
    output logic        err,
    output logic [15:0] req_count
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]   offset;
    logic [29:0]   index;
    logic [AW-1:0] widx;
    logic          in_range;
    logic          legal;
    logic          accept;
    logic          do_wr;
    logic          do_rd;

    logic [31:0] mem [DEPTH_WORDS];

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign offset   = address - BASE_ADDR;
    assign index    = offset[31:2];
    assign widx     = index[AW-1:0];
    assign in_range = (index < 30'(DEPTH_WORDS));
    assign legal    = (read ^ write) && (offset[1:0] == 2'b00) && in_range;
    assign accept   = (state == IDLE) && (read || write);
    assign do_wr    = accept && write && legal;
    assign do_rd    = accept && read && legal;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: RESP lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (read || write) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state == IDLE);
    end

    // Response pulses are registered at the accept edge so they are high for
    // exactly the RESP cycle and low again in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memOut    <= 32'h0;
            rd_valid  <= 1'b0;
            wr_ack    <= 1'b0;
            err       <= 1'b0;
            req_count <= 16'h0;
        end else begin
            rd_valid <= do_rd;
            wr_ack   <= do_wr;
            err      <= accept && !legal;
            if (accept) begin
                req_count <= req_count + 16'd1;
            end
            if (do_rd) begin
                memOut <= mem[widx];
            end
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= FILL_WORD;
            end
        end else if (do_wr) begin
            mem[widx] <= memIn;
        end
    end
`else
    // No reset on the array so it maps onto plain RAM; writes committed
    // before a reset survive it.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[widx] <= memIn;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard testbench for mem_responder

module tb_mem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;
    localparam logic [31:0] FILL  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] memIn = 32'h0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        ready;
    logic [31:0] memOut;
    logic        rd_valid;
    logic        wr_ack;
    logic        err;
    logic [15:0] req_count;

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .FILL_WORD  (FILL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .memIn    (memIn),
        .read     (read),
        .write    (write),
        .ready    (ready),
        .memOut   (memOut),
        .rd_valid (rd_valid),
        .wr_ack   (wr_ack),
        .err      (err),
        .req_count(req_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;   // {rd_valid, wr_ack, err}
        logic [31:0] data;   // expected memOut
        logic [15:0] cnt;    // expected req_count
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [int unsigned];
    logic [31:0] exp_out = 32'h0;
    logic [15:0] exp_cnt = 16'h0;
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          rd_cycles[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_read(input int unsigned idx);
        if (mdl.exists(idx)) return mdl[idx];
`ifdef MEM_CLEAR_ON_RESET_EN
        return FILL;
`else
        return 32'hxxxx_xxxx;
`endif
    endfunction

    // Predict the response of one accepted request and queue it.
    task automatic push_req(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
        logic [31:0] off;
        logic        ok;
        exp_t        e;
        off = addr - BASE;
        ok  = (rd != wr) && (off[1:0] == 2'b00) && (off[31:2] < DEPTH);
        exp_cnt = exp_cnt + 16'd1;
        if (ok && wr) begin
            mdl[off[31:2]] = data;
            e.kind = 3'b010;
        end else if (ok && rd) begin
            exp_out = mdl_read(off[31:2]);
            e.kind = 3'b100;
        end else begin
            e.kind = 3'b001;
        end
        e.data = exp_out;
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    // Drive one request at a falling edge; it is accepted at the next rising edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        check("ready_wait", {31'h0, ready}, 32'h1);
        read = rd; write = wr; address = addr; memIn = data;
        push_req(rd, wr, addr, data);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Response monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (ready) begin
                check("idle_quiet", {29'h0, rd_valid, wr_ack, err}, 32'h0);
            end else begin
                check("onehot", 32'(rd_valid) + 32'(wr_ack) + 32'(err), 32'h1);
                if (rd_valid) rd_cycles.push_back(cycle);
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'(sb.size()), 32'h1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("kind", {29'h0, rd_valid, wr_ack, err}, {29'h0, e.kind});
                    check("memout", memOut, e.data);
                    check("req_count", {16'h0, req_count}, {16'h0, e.cnt});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #13;
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_memout", memOut, 32'h0);
        check("rst_pulses", {29'h0, rd_valid, wr_ack, err}, 32'h0);
        check("rst_count", {16'h0, req_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MEM_CLEAR_ON_RESET_EN
        // First read after reset sees the fill pattern
        req(1'b1, 1'b0, 32'd16, 32'h0);
        check("clear_read", exp_out, FILL);
`else
        req(1'b0, 1'b1, 32'd16, FILL);
        req(1'b0, 1'b1, 32'd24, FILL);
`endif

        // Write then read back
        req(1'b0, 1'b1, 32'd20, 32'd20);
        req(1'b1, 1'b0, 32'd20, 32'h0);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, 32'd16 + 32'(4 * i), 32'h0);
        end

        // Misaligned write is rejected and changes nothing
        req(1'b0, 1'b1, 32'd19, 32'd20);
        req(1'b1, 1'b0, 32'd16, 32'h0);
        req(1'b1, 1'b0, 32'd20, 32'h0);

        // Conflict and range boundaries
        req(1'b1, 1'b1, 32'd20, 32'h1234);
        req(1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0);
        req(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'h5555);
        req(1'b0, 1'b1, 32'd1020, 32'hCAFE_F00D);
        req(1'b1, 1'b0, 32'd1020, 32'h0);
        req(1'b1, 1'b0, 32'd20, 32'h0);

        // Handshake: read held high for six cycles
        @(negedge clk);
        rd_cycles.delete();
        read = 1'b1; address = 32'd20;
        for (int i = 0; i < 6; i++) begin
            check("hs_ready", {31'h0, ready}, {31'h0, (i % 2 == 0)});
            if (ready) push_req(1'b1, 1'b0, 32'd20, 32'h0);
            @(negedge clk);
        end
        read = 1'b0;
        @(negedge clk);
        check("hs_pulses", 32'(rd_cycles.size()), 32'd3);
        if (rd_cycles.size() == 3) begin
            check("hs_gap1", 32'(rd_cycles[1] - rd_cycles[0]), 32'd2);
            check("hs_gap2", 32'(rd_cycles[2] - rd_cycles[1]), 32'd2);
        end

        // Async reset in the middle of a write response
        @(negedge clk);
        write = 1'b1; address = 32'd28; memIn = 32'hDEAD_BEEF;
        @(posedge clk);
        #2;
        write = 1'b0;
        check("mid_wr_ack", {31'h0, wr_ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_wr_ack", {31'h0, wr_ack}, 32'h0);
        check("rst_count2", {16'h0, req_count}, 32'h0);
        check("rst_ready2", {31'h0, ready}, 32'h1);
        check("rst_memout2", memOut, 32'h0);
`ifdef MEM_CLEAR_ON_RESET_EN
        mdl.delete();
`else
        mdl[7] = 32'hDEAD_BEEF;
`endif
        exp_cnt = 16'h0;
        exp_out = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        req(1'b1, 1'b0, 32'd28, 32'h0);
`ifndef MEM_CLEAR_ON_RESET_EN
        check("kept_write", exp_out, 32'hDEAD_BEEF);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
